// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg
//    Shared MIPS encoding definitions used by the instruction encoder and the
//    opcode/control decoder. It holds the mnemonic indices, primary opcodes,
//    funct codes and small helpers that assemble the three MIPS word formats.
//    Ports: none (package).
package instr_encoder_pkg;

   // Mnemonic indices presented on in_op. Values 11..15 are illegal.
   localparam logic [3:0] MN_LW   = 4'd0;
   localparam logic [3:0] MN_SW   = 4'd1;
   localparam logic [3:0] MN_J    = 4'd2;
   localparam logic [3:0] MN_JR   = 4'd3;
   localparam logic [3:0] MN_JAL  = 4'd4;
   localparam logic [3:0] MN_BNE  = 4'd5;
   localparam logic [3:0] MN_XORI = 4'd6;
   localparam logic [3:0] MN_ADDI = 4'd7;
   localparam logic [3:0] MN_ADD  = 4'd8;
   localparam logic [3:0] MN_SUB  = 4'd9;
   localparam logic [3:0] MN_SLT  = 4'd10;

   // Primary opcodes, instr[31:26].
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_ADDI  = 6'h08;

   // R-type funct codes, instr[5:0].
   localparam logic [5:0] FN_JR  = 6'h08;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_SLT = 6'h2A;

   // Instruction formats, handy for decoders and reference models.
   typedef enum logic [1:0] {
      FMT_R,
      FMT_I,
      FMT_J
   } instrFmt_e;

   // shamt is always zero for the supported R-type set.
   function automatic logic [31:0] packRType(input logic [4:0] rs,
                                             input logic [4:0] rt,
                                             input logic [4:0] rd,
                                             input logic [5:0] funct);
      return {OP_RTYPE, rs, rt, rd, 5'd0, funct};
   endfunction

   function automatic logic [31:0] packIType(input logic [5:0]  opcode,
                                             input logic [4:0]  rs,
                                             input logic [4:0]  rt,
                                             input logic [15:0] imm);
      return {opcode, rs, rt, imm};
   endfunction

   function automatic logic [31:0] packJType(input logic [5:0]  opcode,
                                             input logic [25:0] target);
      return {opcode, target};
   endfunction

endpackage

// File: rtl/instr_encoder_field_pack.sv
// instr_field_pack
//    Combinational field packer: mnemonic index plus raw fields in, MIPS machine
//    word and a legality flag out. Fields a format does not use are forced to
//    zero, so the result never depends on them. Reusable by reference models.
//    Ports:
//       op      in   4   mnemonic index (0..10 legal)
//       rs      in   5   source register
//       rt      in   5   target register
//       rd      in   5   destination register (R-type)
//       imm     in  16   immediate / branch offset
//       target  in  26   jump target (J/JAL)
//       legal   out  1   op is a supported mnemonic
//       instr   out 32   encoded word (zero when illegal)
module instr_field_pack
   import instr_encoder_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] target,
   output logic        legal,
   output logic [31:0] instr
);

   always_comb begin
      legal = 1'b1;
      instr = '0;
      case (op)
         MN_LW:   instr = packIType(OP_LW,   rs, rt, imm);
         MN_SW:   instr = packIType(OP_SW,   rs, rt, imm);
         MN_J:    instr = packJType(OP_J,    target);
         MN_JR:   instr = packRType(rs, 5'd0, 5'd0, FN_JR);
         MN_JAL:  instr = packJType(OP_JAL,  target);
         MN_BNE:  instr = packIType(OP_BNE,  rs, rt, imm);
         MN_XORI: instr = packIType(OP_XORI, rs, rt, imm);
         MN_ADDI: instr = packIType(OP_ADDI, rs, rt, imm);
         MN_ADD:  instr = packRType(rs, rt, rd, FN_ADD);
         MN_SUB:  instr = packRType(rs, rt, rd, FN_SUB);
         MN_SLT:  instr = packRType(rs, rt, rd, FN_SLT);
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder
//    Turns mnemonic/field bundles into MIPS machine words tagged with a
//    sequential byte address, for loading instruction memory. Valid/ready on
//    both sides with a 2-entry FIFO on the output. Illegal mnemonics are
//    consumed, counted and flagged but produce no word.
//    Ports:
//       clk, reset            clock, synchronous active-high reset
//       in_valid/in_ready     input handshake
//       in_op, in_rs, in_rt, in_rd, in_imm, in_target   instruction fields
//       load_addr/load_value  one-cycle load of the address counter
//       out_valid/out_ready   output handshake
//       out_instr, out_addr   head-of-buffer word and its byte address
//       err                   pulse the cycle after an illegal bundle is taken
//       illegal_count         saturating count of illegal bundles
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int                 ADDR_W     = 32,
   parameter logic [ADDR_W-1:0]  RESET_ADDR = '0
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [3:0]        in_op,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   input  logic              load_addr,
   input  logic [ADDR_W-1:0] load_value,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic [7:0]        illegal_count
);

   localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

   logic              packLegal;
   logic [31:0]       packInstr;

   logic [31:0]       bufInstr [2];
   logic [ADDR_W-1:0] bufAddr  [2];
   logic              rdPtr;
   logic              wrPtr;
   logic [1:0]        count;
   logic [ADDR_W-1:0] addrCnt;

   logic              accept;
   logic              push;
   logic              pop;
   logic [ADDR_W-1:0] tagAddr;

   instr_field_pack uPack (
      .op     (in_op),
      .rs     (in_rs),
      .rt     (in_rt),
      .rd     (in_rd),
      .imm    (in_imm),
      .target (in_target),
      .legal  (packLegal),
      .instr  (packInstr)
   );

   // Handshake flags come straight from buffer state, so in_ready has no
   // path from out_ready. A push at count 2 is impossible by construction.
   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign out_instr = bufInstr[rdPtr];
   assign out_addr  = bufAddr[rdPtr];

   assign accept  = in_valid && in_ready;
   assign push    = accept && packLegal;
   assign pop     = out_valid && out_ready;
   // A coincident load wins over the running counter for this word's tag.
   assign tagAddr = load_addr ? load_value : addrCnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         rdPtr         <= 1'b0;
         wrPtr         <= 1'b0;
         count         <= 2'd0;
         addrCnt       <= RESET_ADDR;
         err           <= 1'b0;
         illegal_count <= 8'd0;
      end else begin
         if (push) wrPtr <= ~wrPtr;
         if (pop)  rdPtr <= ~rdPtr;

         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase

         if (push)           addrCnt <= tagAddr + ADDR_STEP;
         else if (load_addr) addrCnt <= load_value;

         err <= accept && !packLegal;
         if (accept && !packLegal && illegal_count != 8'hFF)
            illegal_count <= illegal_count + 8'd1;
      end
   end

   // Storage needs no reset: count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         bufInstr[wrPtr] <= packInstr;
         bufAddr[wrPtr]  <= tagAddr;
      end
   end

endmodule
